// File: rtl/sayeh_fetch_unit.sv
// SAYEH instruction fetch / pre-decode unit: reads 16-bit words from
// memory, splits them into byte-coded instructions, hands them out.
//
// Parameters:
//   ADDR_W    word-address width of Addressbus and PC
//   RESET_PC  PC value loaded on reset
// Ports:
//   clk, ExternalReset         clock, async active-low reset
//   ReadMem, Addressbus        memory read request and word address
//   Databus, MemDataready      read data and acknowledge
//   pc_load, pc_value          redirect request and target
//   instr_valid, instr_ready   instruction handshake
//   instr_op/rd/rs/imm         opcode byte, its fields, immediate byte
//   instr_has_imm              instruction carries an immediate
//   instr_addr, instr_half     word address / byte lane of the opcode
//   illegal                    undefined opcode (trap build only)
// Build option:
//   SAYEH_FETCH_ILLEGAL_TRAP_EN  present bytes 0B-0F as illegal and halt
//                                after accept; otherwise they become nop.

module sayeh_fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              ExternalReset,
    output logic              ReadMem,
    output logic [ADDR_W-1:0] Addressbus,
    input  logic [15:0]       Databus,
    input  logic              MemDataready,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_value,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [7:0]        instr_op,
    output logic [1:0]        instr_rd,
    output logic [1:0]        instr_rs,
    output logic [7:0]        instr_imm,
    output logic              instr_has_imm,
    output logic [ADDR_W-1:0] instr_addr,
    output logic              instr_half,
    output logic              illegal
);

`ifdef SAYEH_FETCH_ILLEGAL_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        FETCH,
        PRESENT_HI,
        PRESENT_LO,
        FETCH_IMM,
        PRESENT_SPLIT,
        HALT
    } stateType;

    stateType          state;
    stateType          stateNxt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pcNxt;
    logic [15:0]       word;
    logic [15:0]       wordNxt;
    logic [7:0]        splitOp;
    logic [7:0]        splitOpNxt;
    logic              dropPend;
    logic              dropNxt;

    logic              readMemNxt;
    logic [ADDR_W-1:0] addrBusNxt;
    logic              validNxt;
    logic [7:0]        opNxt;
    logic [7:0]        immNxt;
    logic              hasImmNxt;
    logic [ADDR_W-1:0] instrAddrNxt;
    logic              halfNxt;
    logic              illegalNxt;

    logic              readDone;
    logic              accept;
    logic [ADDR_W-1:0] pcInc;
    logic [7:0]        hiByte;
    logic [7:0]        loByte;

    function automatic logic isImm(input logic [7:0] b);
        return (b[7:4] == 4'hF) || (b >= 8'h07 && b <= 8'h0A);
    endfunction

    function automatic logic isUndef(input logic [7:0] b);
        return (b >= 8'h0B) && (b <= 8'h0F);
    endfunction

    function automatic logic isTrap(input logic [7:0] b);
        return TRAP_EN && isUndef(b);
    endfunction

    // Without the trap, undefined bytes are turned into nop here.
    function automatic logic [7:0] mapOp(input logic [7:0] b);
        return (!TRAP_EN && isUndef(b)) ? 8'h00 : b;
    endfunction

    assign readDone = ReadMem && MemDataready;
    assign accept   = instr_valid && instr_ready && !pc_load;
    assign pcInc    = pc + ADDR_W'(1);
    assign hiByte   = word[15:8];
    assign loByte   = word[7:0];
    assign instr_rd = instr_op[3:2];
    assign instr_rs = instr_op[1:0];

    always_ff @(posedge clk or negedge ExternalReset) begin
        if (!ExternalReset) begin
            state         <= FETCH;
            pc            <= RESET_PC;
            word          <= '0;
            splitOp       <= '0;
            dropPend      <= 1'b0;
            ReadMem       <= 1'b0;
            Addressbus    <= RESET_PC;
            instr_valid   <= 1'b0;
            instr_op      <= '0;
            instr_imm     <= '0;
            instr_has_imm <= 1'b0;
            instr_addr    <= '0;
            instr_half    <= 1'b0;
            illegal       <= 1'b0;
        end else begin
            state         <= stateNxt;
            pc            <= pcNxt;
            word          <= wordNxt;
            splitOp       <= splitOpNxt;
            dropPend      <= dropNxt;
            ReadMem       <= readMemNxt;
            Addressbus    <= addrBusNxt;
            instr_valid   <= validNxt;
            instr_op      <= opNxt;
            instr_imm     <= immNxt;
            instr_has_imm <= hasImmNxt;
            instr_addr    <= instrAddrNxt;
            instr_half    <= halfNxt;
            illegal       <= illegalNxt;
        end
    end

    always_comb begin
        stateNxt   = state;
        pcNxt      = pc;
        wordNxt    = word;
        splitOpNxt = splitOp;
        dropNxt    = dropPend;
        if (pc_load) begin
            // A read still in flight must finish on the bus; its data
            // is thrown away when it arrives.
            stateNxt = FETCH;
            pcNxt    = pc_value;
            dropNxt  = ReadMem && !MemDataready;
        end else begin
            unique case (state)
                FETCH: begin
                    if (readDone) begin
                        if (dropPend) begin
                            dropNxt = 1'b0;
                        end else begin
                            wordNxt  = Databus;
                            stateNxt = PRESENT_HI;
                        end
                    end
                end
                PRESENT_HI: begin
                    if (accept) begin
                        if (isImm(hiByte)) begin
                            pcNxt    = pcInc;
                            stateNxt = FETCH;
                        end else if (isTrap(hiByte)) begin
                            stateNxt = HALT;
                        end else begin
                            stateNxt = PRESENT_LO;
                        end
                    end
                end
                PRESENT_LO: begin
                    // Immediate opcode in the low lane: its operand is
                    // the high byte of the next word.
                    if (isImm(loByte)) begin
                        pcNxt      = pcInc;
                        splitOpNxt = loByte;
                        stateNxt   = FETCH_IMM;
                    end else if (accept) begin
                        if (isTrap(loByte)) begin
                            stateNxt = HALT;
                        end else begin
                            pcNxt    = pcInc;
                            stateNxt = FETCH;
                        end
                    end
                end
                FETCH_IMM: begin
                    if (readDone) begin
                        wordNxt  = Databus;
                        stateNxt = PRESENT_SPLIT;
                    end
                end
                PRESENT_SPLIT: begin
                    if (accept) begin
                        stateNxt = PRESENT_LO;
                    end
                end
                HALT: begin
                    stateNxt = HALT;
                end
                default: begin
                    stateNxt = FETCH;
                end
            endcase
        end
    end

    // Outputs are registered, so they are derived from the next state
    // and next datapath values.
    always_comb begin
        readMemNxt   = ((stateNxt == FETCH) || (stateNxt == FETCH_IMM))
                       && !readDone;
        addrBusNxt   = (ReadMem && !MemDataready) ? Addressbus : pcNxt;
        validNxt     = 1'b0;
        opNxt        = '0;
        immNxt       = '0;
        hasImmNxt    = 1'b0;
        instrAddrNxt = '0;
        halfNxt      = 1'b0;
        illegalNxt   = 1'b0;
        unique case (stateNxt)
            PRESENT_HI: begin
                validNxt     = 1'b1;
                opNxt        = mapOp(wordNxt[15:8]);
                hasImmNxt    = isImm(wordNxt[15:8]);
                immNxt       = hasImmNxt ? wordNxt[7:0] : 8'h00;
                instrAddrNxt = pcNxt;
                illegalNxt   = isTrap(wordNxt[15:8]);
            end
            PRESENT_LO: begin
                if (!isImm(wordNxt[7:0])) begin
                    validNxt     = 1'b1;
                    opNxt        = mapOp(wordNxt[7:0]);
                    instrAddrNxt = pcNxt;
                    halfNxt      = 1'b1;
                    illegalNxt   = isTrap(wordNxt[7:0]);
                end
            end
            PRESENT_SPLIT: begin
                validNxt     = 1'b1;
                opNxt        = splitOpNxt;
                immNxt       = wordNxt[15:8];
                hasImmNxt    = 1'b1;
                instrAddrNxt = pcNxt - ADDR_W'(1);
                halfNxt      = 1'b1;
            end
            default: begin
                validNxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sayeh_fetch_unit.sv
// Directed bench for sayeh_fetch_unit with a behavioural memory
// model that supports a programmable number of wait states.

module tb_sayeh_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ReadMem;
    logic [15:0] Addressbus;
    logic [15:0] Databus;
    logic        MemDataready;
    logic        pc_load;
    logic [15:0] pc_value;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  instr_op;
    logic [1:0]  instr_rd;
    logic [1:0]  instr_rs;
    logic [7:0]  instr_imm;
    logic        instr_has_imm;
    logic [15:0] instr_addr;
    logic        instr_half;
    logic        illegal;

    logic [15:0] mem [0:65535];
    int          waitStates = 0;
    int          waitCnt = 0;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    assign MemDataready = ReadMem && (waitCnt >= waitStates);
    assign Databus      = mem[Addressbus];

    always @(posedge clk)
        waitCnt <= (ReadMem && !MemDataready) ? waitCnt + 1 : 0;

    sayeh_fetch_unit dut (
        .clk(clk), .ExternalReset(rst_n),
        .ReadMem(ReadMem), .Addressbus(Addressbus),
        .Databus(Databus), .MemDataready(MemDataready),
        .pc_load(pc_load), .pc_value(pc_value),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs),
        .instr_imm(instr_imm), .instr_has_imm(instr_has_imm),
        .instr_addr(instr_addr), .instr_half(instr_half),
        .illegal(illegal)
    );

    function automatic logic [34:0] obs();
        return {illegal, instr_op, instr_imm, instr_has_imm,
                instr_half, instr_addr};
    endfunction

    function automatic logic [34:0] pack(input logic ill,
        input logic [7:0] op, input logic [7:0] imm,
        input logic h, input logic half, input logic [15:0] a);
        return {ill, op, imm, h, half, a};
    endfunction

    task automatic waitValid(output bit ok, output int cyc);
        ok = 0; cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (instr_valid) begin ok = 1; cyc = i; break; end
        end
    endtask

    task automatic waitRead(output bit ok, output int cyc);
        ok = 0; cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (ReadMem) begin ok = 1; cyc = i; break; end
        end
    endtask

    task automatic redirect(input logic [15:0] a);
        pc_load = 1'b1; pc_value = a;
        @(negedge clk);
        pc_load = 1'b0;
    endtask

    task automatic doReset();
        rst_n = 1'b0; instr_ready = 1'b0; pc_load = 1'b0;
        waitStates = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        mem[0] = 16'h16B3; mem[1] = 16'h0000;
        doReset();
        tests++;
        if ({ReadMem, Addressbus, instr_valid, obs(), instr_rd, instr_rs}
            !== 56'd0) begin
            fails++;
            $display("FAIL reset_state: got rm=%b ab=%h v=%b o=%h",
                     ReadMem, Addressbus, instr_valid, obs());
        end
        @(negedge clk);
        tests++;
        if (ReadMem !== 1'b1 || Addressbus !== 16'h0000) begin
            fails++;
            $display("FAIL reset_first_read: got rm=%b ab=%h want 1/0000",
                     ReadMem, Addressbus);
        end
    endtask

    task automatic test_short_pair();
        bit ok; int cyc;
        instr_ready = 1'b1;
        waitValid(ok, cyc);
        tests++;
        if (!ok || cyc != 1 || obs() !== pack(0, 8'h16, 0, 0, 0, 16'h0)) begin
            fails++;
            $display("FAIL short_hi: got %h cyc %0d want %h cyc 1",
                     obs(), cyc, pack(0, 8'h16, 0, 0, 0, 16'h0));
        end
        waitValid(ok, cyc);
        tests++;
        if (!ok || cyc != 1 || obs() !== pack(0, 8'hB3, 0, 0, 1, 16'h0)
            || instr_rd !== 2'd0 || instr_rs !== 2'd3) begin
            fails++;
            $display("FAIL short_lo: got %h rd %0d rs %0d cyc %0d want %h",
                     obs(), instr_rd, instr_rs, cyc,
                     pack(0, 8'hB3, 0, 0, 1, 16'h0));
        end
        waitRead(ok, cyc);
        tests++;
        if (!ok || cyc != 1 || Addressbus !== 16'h0001) begin
            fails++;
            $display("FAIL short_next_fetch: got ab=%h cyc %0d want 0001 1",
                     Addressbus, cyc);
        end
    endtask

    task automatic test_immediate();
        bit ok; int cyc;
        mem[0] = 16'hF45A; mem[1] = 16'h0000;
        doReset();
        instr_ready = 1'b1;
        waitValid(ok, cyc);
        tests++;
        if (!ok || obs() !== pack(0, 8'hF4, 8'h5A, 1, 0, 16'h0)
            || instr_rd !== 2'd1 || instr_rs !== 2'd0) begin
            fails++;
            $display("FAIL imm_instr: got %h rd %0d want %h rd 1",
                     obs(), instr_rd, pack(0, 8'hF4, 8'h5A, 1, 0, 16'h0));
        end
        waitRead(ok, cyc);
        tests++;
        if (!ok || cyc != 1 || Addressbus !== 16'h0001) begin
            fails++;
            $display("FAIL imm_next_fetch: got ab=%h cyc %0d want 0001 1",
                     Addressbus, cyc);
        end
    endtask

    task automatic test_split();
        bit ok; int cyc;
        mem[4] = 16'h1608; mem[5] = 16'h3300; mem[6] = 16'h0000;
        redirect(16'h0004);
        waitValid(ok, cyc);
        tests++;
        if (!ok || obs() !== pack(0, 8'h16, 0, 0, 0, 16'h4)) begin
            fails++;
            $display("FAIL split_first: got %h want %h",
                     obs(), pack(0, 8'h16, 0, 0, 0, 16'h4));
        end
        waitValid(ok, cyc);
        tests++;
        if (!ok || obs() !== pack(0, 8'h08, 8'h33, 1, 1, 16'h4)) begin
            fails++;
            $display("FAIL split_imm: got %h want %h",
                     obs(), pack(0, 8'h08, 8'h33, 1, 1, 16'h4));
        end
        waitValid(ok, cyc);
        tests++;
        if (!ok || cyc != 1 || obs() !== pack(0, 8'h00, 0, 0, 1, 16'h5)) begin
            fails++;
            $display("FAIL split_tail: got %h cyc %0d want %h",
                     obs(), cyc, pack(0, 8'h00, 0, 0, 1, 16'h5));
        end
        waitRead(ok, cyc);
        tests++;
        if (!ok || Addressbus !== 16'h0006) begin
            fails++;
            $display("FAIL split_next_fetch: got ab=%h want 0006", Addressbus);
        end
    endtask

    task automatic test_back_to_back();
        bit ok; int cyc; bit stable; bit sawValid;
        mem[8] = 16'hF123; mem[9] = 16'hF4AA; mem[16] = 16'h2145;
        instr_ready = 1'b0;
        redirect(16'h0008);
        waitValid(ok, cyc);
        stable = ok;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!instr_valid || obs() !== pack(0, 8'hF1, 8'h23, 1, 0, 16'h8))
                stable = 0;
        end
        tests++;
        if (!stable) begin
            fails++;
            $display("FAIL backpressure_hold: got v=%b %h want 1 %h",
                     instr_valid, obs(), pack(0, 8'hF1, 8'h23, 1, 0, 16'h8));
        end
        waitStates = 3;
        instr_ready = 1'b1;
        waitRead(ok, cyc);
        tests++;
        if (!ok || Addressbus !== 16'h0009) begin
            fails++;
            $display("FAIL wait_read_addr: got ab=%h want 0009", Addressbus);
        end
        redirect(16'h0010);
        tests++;
        if (ReadMem !== 1'b1 || Addressbus !== 16'h0009) begin
            fails++;
            $display("FAIL redirect_hold: got rm=%b ab=%h want 1 0009",
                     ReadMem, Addressbus);
        end
        ok = 0; sawValid = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (instr_valid) sawValid = 1;
            if (!ReadMem) begin ok = 1; break; end
        end
        waitStates = 0;
        waitRead(ok, cyc);
        tests++;
        if (!ok || sawValid || Addressbus !== 16'h0010) begin
            fails++;
            $display("FAIL redirect_fetch: got ab=%h stale=%b want 0010 0",
                     Addressbus, sawValid);
        end
        waitValid(ok, cyc);
        tests++;
        if (!ok || obs() !== pack(0, 8'h21, 0, 0, 0, 16'h10)) begin
            fails++;
            $display("FAIL redirect_instr: got %h want %h",
                     obs(), pack(0, 8'h21, 0, 0, 0, 16'h10));
        end
    endtask

    task automatic test_wrap();
        bit ok; int cyc;
        mem[16'hFFFF] = 16'h0000;
        instr_ready = 1'b0;
        waitValid(ok, cyc);
        redirect(16'hFFFF);
        tests++;
        if (!ok || instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL redirect_drop_valid: got v=%b want 0", instr_valid);
        end
        instr_ready = 1'b1;
        waitValid(ok, cyc);
        tests++;
        if (!ok || obs() !== pack(0, 8'h00, 0, 0, 0, 16'hFFFF)) begin
            fails++;
            $display("FAIL wrap_hi: got %h want %h",
                     obs(), pack(0, 8'h00, 0, 0, 0, 16'hFFFF));
        end
        waitValid(ok, cyc);
        tests++;
        if (!ok || obs() !== pack(0, 8'h00, 0, 0, 1, 16'hFFFF)) begin
            fails++;
            $display("FAIL wrap_lo: got %h want %h",
                     obs(), pack(0, 8'h00, 0, 0, 1, 16'hFFFF));
        end
        waitRead(ok, cyc);
        tests++;
        if (!ok || Addressbus !== 16'h0000) begin
            fails++;
            $display("FAIL wrap_fetch: got ab=%h want 0000", Addressbus);
        end
    endtask

    task automatic test_illegal();
        bit ok; int cyc;
`ifdef SAYEH_FETCH_ILLEGAL_TRAP_EN
        bit quiet;
`endif
        mem[0] = 16'h0C00; mem[1] = 16'h0000;
        doReset();
        instr_ready = 1'b1;
        waitValid(ok, cyc);
`ifdef SAYEH_FETCH_ILLEGAL_TRAP_EN
        tests++;
        if (!ok || obs() !== pack(1, 8'h0C, 0, 0, 0, 16'h0)) begin
            fails++;
            $display("FAIL illegal_flag: got %h want %h",
                     obs(), pack(1, 8'h0C, 0, 0, 0, 16'h0));
        end
        quiet = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ReadMem || instr_valid) quiet = 0;
        end
        tests++;
        if (!quiet) begin
            fails++;
            $display("FAIL illegal_halt: got rm=%b v=%b want 0 0",
                     ReadMem, instr_valid);
        end
        redirect(16'h0000);
        waitRead(ok, cyc);
        tests++;
        if (!ok || Addressbus !== 16'h0000) begin
            fails++;
            $display("FAIL halt_resume: got ab=%h want 0000", Addressbus);
        end
`else
        tests++;
        if (!ok || obs() !== pack(0, 8'h00, 0, 0, 0, 16'h0)) begin
            fails++;
            $display("FAIL illegal_nop_hi: got %h want %h",
                     obs(), pack(0, 8'h00, 0, 0, 0, 16'h0));
        end
        waitValid(ok, cyc);
        tests++;
        if (!ok || obs() !== pack(0, 8'h00, 0, 0, 1, 16'h0)) begin
            fails++;
            $display("FAIL illegal_nop_lo: got %h want %h",
                     obs(), pack(0, 8'h00, 0, 0, 1, 16'h0));
        end
        waitRead(ok, cyc);
        tests++;
        if (!ok || Addressbus !== 16'h0001) begin
            fails++;
            $display("FAIL illegal_continue: got ab=%h want 0001", Addressbus);
        end
`endif
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        rst_n = 1'b1; pc_load = 1'b0; pc_value = 16'h0000;
        instr_ready = 1'b0;
        #3;
        test_reset();
        test_short_pair();
        test_immediate();
        test_split();
        test_back_to_back();
        test_wrap();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sayeh_fetch_unit.md
# sayeh_fetch_unit

Synthesizable instruction-fetch and pre-decode unit for the SAYEH CPU. It acts as the bus initiator on the word-wide memory read protocol (ReadMem / Addressbus / Databus / MemDataready). It unpacks each fetched 16-bit word into one or two byte-coded instructions, with optional 8-bit immediates, and hands them to the CPU controller over a valid/ready handshake. It sits between the memory port and the controller.

## Interface
Parameters:
- ADDR_W, 16, word-address width of Addressbus and PC.
- RESET_PC, 16'h0000, PC loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- ExternalReset  in  1  asynchronous, active-low reset.
- ReadMem  out  1  memory read request.
- Addressbus  out  ADDR_W  word address of the current fetch.
- Databus  in  16  read data; valid when MemDataready=1.
- MemDataready  in  1  memory read acknowledge.
- pc_load  in  1  one-cycle redirect request (jump/branch/reset vector).
- pc_value  in  ADDR_W  redirect target word address.
- instr_valid  out  1  decoded instruction available.
- instr_ready  in  1  controller accepts instruction.
- instr_op  out  8  opcode byte.
- instr_rd  out  2  instr_op[3:2].
- instr_rs  out  2  instr_op[1:0].
- instr_imm  out  8  immediate byte; 0 when has_imm=0.
- instr_has_imm  out  1  instruction carries an immediate.
- instr_addr  out  ADDR_W  word address of the opcode byte.
- instr_half  out  1  0 = opcode in [15:8], 1 = opcode in [7:0].
- illegal  out  1  illegal-opcode flag (see Configuration).

## Operation
- Encoding: the opcode is a byte.
  - Immediate form: upper nibble 4'hF (mil/mih/spc/jpa), or byte 8'h07–8'h0A (jpr/brz/brc/awp).
  - All other bytes are short form.
  - Bytes 8'h0B–8'h0F are undefined.
- Normal placement: an immediate instruction occupies a whole word, opcode in [15:8], immediate in [7:0]. A short instruction in [15:8] is followed by a second instruction in [7:0].
- FSM states: FETCH, PRESENT_HI, PRESENT_LO, FETCH_IMM, PRESENT_SPLIT, HALT.
- FETCH:
  - Drive ReadMem=1 and Addressbus=PC.
  - On MemDataready=1, latch Databus into the word register and go to PRESENT_HI.
- PRESENT_HI:
  - Present byte [15:8].
  - If immediate form: imm=[7:0]; on accept, PC=PC+1 and go to FETCH.
  - Otherwise: on accept, go to PRESENT_LO.
- PRESENT_LO:
  - Present byte [7:0].
  - Short form: on accept, PC=PC+1 and go to FETCH.
  - Immediate form (split across a word boundary): PC=PC+1, go to FETCH_IMM without presenting.
- FETCH_IMM:
  - Read the word at PC; its [15:8] becomes the immediate.
  - Go to PRESENT_SPLIT. instr_addr and instr_half=1 refer to the original opcode location.
  - On accept, go to PRESENT_LO on the new word.
- PC arithmetic: ADDR_W-bit, wraps 16'hFFFF -> 16'h0000 with no flag.
- pc_load:
  - Highest priority. PC=pc_value, instr_valid drops next cycle, any presented instruction is discarded.
  - If a read is outstanding, ReadMem stays high until MemDataready; that data is dropped, then FETCH restarts at pc_value.
- pc_load together with instr_ready: pc_load wins; the instruction counts as not accepted.

## Timing
- Reset values:
  - ReadMem=0, Addressbus=RESET_PC, instr_valid=0, all instr_* outputs =0, illegal=0.
  - State = FETCH; ReadMem rises on the first edge after reset release.
- ReadMem, Addressbus and all instr_* outputs are registered. Addressbus is stable while ReadMem=1.
- ReadMem falls on the edge that samples MemDataready=1. Minimum 2 cycles between successive requests.
- Read latency: instr_valid rises 1 cycle after the MemDataready sample.
- Low-byte instruction: presented the cycle after the high byte is accepted, with no bus access.
- Handshake: instr_* outputs are held stable while instr_valid=1 and instr_ready=0. Accept = valid & ready on a rising edge.
- Throughput with zero-wait memory and instr_ready tied high: 2 short instructions per 3 cycles.

## Configuration
- SAYEH_FETCH_ILLEGAL_TRAP_EN
  - Defined: bytes 8'h0B–8'h0F are presented with illegal=1. After accept, the FSM enters HALT, with ReadMem=0 and instr_valid=0, until pc_load.
  - Undefined: these bytes are presented as nop (instr_op=8'h00, illegal tied 0). Fetch continues.

## Test plan
- Short pair: mem[0]=16'h16B3, zero-wait, ready=1.
  - Expect: op 16 (addr 0, half 0), then op B3 (addr 0, half 1).
  - Then ReadMem with Addressbus=0001.
- Immediate: mem[0]=16'hF45A.
  - Expect one instruction: op F4, rd=1, imm 5A, has_imm=1.
  - Next fetch at 0001.
- Split immediate: mem[4]=16'h1608, mem[5]=16'h3300, pc_load 0004.
  - Expect: op 16, then op 08 with imm 33 (addr 4, half 1), then op 00 (addr 5, half 1).
- Backpressure and redirect: hold ready=0 for 5 cycles; outputs stay constant.
  - Assert pc_load=0010 while a read is outstanding with 3 wait states.
  - Expect: stale data dropped; next ReadMem at 0010.
- Wrap: pc_load FFFF, mem[FFFF]=16'h0000.
  - Expect: two nops, then fetch at 0000.
- Illegal byte: mem[0]=16'h0C00.
  - With the macro: illegal=1, HALT, ReadMem stays 0 until pc_load.
  - Without the macro: op 00, then op 00, fetch continues at 0001.
